// File: rtl/regfile_pkg.sv
// Shared constants and dump FSM state encoding for the 4 x 32-bit register file
// and its read-side dump initiator.
package regfile_pkg;

  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 32;

  localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_e;

  // Limits a requested dump length so no register is emitted twice.
  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] req);
    logic [ADDR_W:0] res;
    if (req > MAX_COUNT) begin
      res = MAX_COUNT;
    end else begin
      res = req;
    end
    return res;
  endfunction

  // Folds one accepted beat into the running dump checksum.
  function automatic logic [DATA_W-1:0] csum_update(input logic [DATA_W-1:0] acc,
                                                    input logic [DATA_W-1:0] word);
    return acc ^ word;
  endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Read-side dump initiator: walks a wrap-around register range through one read
// port and streams each word on a valid/ready channel with a running XOR checksum.
module regfile_dump_reader
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [ADDR_W:0]   count_clamped_s;

  assign count_clamped_s = clamp_count(count);

  // Next-state and next-output computation for the dump FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    checksum_d  = checksum_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          checksum_d = {DATA_W{1'b0}};
          busy_d     = 1'b1;
          if (count_clamped_s != {(ADDR_W + 1){1'b0}}) begin
            state_d     = READ;
            addr_d      = first_reg;
            remaining_d = count_clamped_s;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end

      READ: begin
        out_data_d  = rf_read_data;
        out_addr_d  = addr_q;
        out_valid_d = 1'b1;
        out_last_d  = (remaining_q == (ADDR_W + 1)'(1));
        state_d     = SEND;
      end

      SEND: begin
        if (out_ready) begin
          checksum_d  = csum_update(checksum_q, out_data_q);
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            // Address wraps naturally at the ADDR_W boundary.
            addr_d      = addr_q + ADDR_W'(1);
            remaining_d = remaining_q - (ADDR_W + 1)'(1);
            state_d     = READ;
          end
        end else begin
          state_d = SEND;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any dump in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      remaining_q <= {(ADDR_W + 1){1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_addr_q  <= {ADDR_W{1'b0}};
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      checksum_q  <= checksum_d;
    end
  end

  // addr_q only changes on entry to READ, so it doubles as the held read address.
  assign rf_read_addr = addr_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_addr     = out_addr_q;
  assign out_last     = out_last_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign checksum     = checksum_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a small clocked register-file model.
module tb_regfile_dump_reader;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] first_reg = '0;
  logic [ADDR_W:0]   count = '0;
  logic [ADDR_W-1:0] rf_read_addr;
  logic [DATA_W-1:0] rf_read_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  logic              load = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [DATA_W-1:0] exp_mem [NUM_REGS];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) begin
      rf[0] <= 32'h11111111;
      rf[1] <= 32'h22222222;
      rf[2] <= 32'h33333333;
      rf[3] <= 32'h44444444;
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  assign rf_read_data = rf[rf_read_addr];

  regfile_dump_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .first_reg    (first_reg),
    .count        (count),
    .rf_read_addr (rf_read_addr),
    .rf_read_data (rf_read_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_addr     (out_addr),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .checksum     (checksum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] f, input logic [ADDR_W:0] c);
    @(negedge clk);
    start = 1'b1;
    first_reg = f;
    count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one dump to completion; n is the expected (clamped) beat count.
  task automatic collect(input logic [ADDR_W-1:0] first, input int n, input int stall_beat,
                         input int stall_len, input int hazard_cyc, input logic [31:0] exp_csum);
    int beats = 0;
    int stall_cnt = 0;
    int done_cyc = -1;
    logic [ADDR_W-1:0] ea;
    for (int cyc = 0; cyc < 200; cyc++) begin
      start = (cyc == hazard_cyc);
      if (cyc == hazard_cyc) begin
        first_reg = 2'd2;
        count = 3'd1;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (out_valid) begin
        ea = first + beats[ADDR_W-1:0];
        if (beats == stall_beat && stall_cnt < stall_len) begin
          out_ready = 1'b0;
          stall_cnt++;
          check("stall_data", out_data, exp_mem[ea]);
          check("stall_addr", 32'(out_addr), 32'(ea));
          check("stall_raddr", 32'(rf_read_addr), 32'(ea));
        end else begin
          out_ready = 1'b1;
          check("beat_data", out_data, exp_mem[ea]);
          check("beat_addr", 32'(out_addr), 32'(ea));
          check("beat_last", 32'(out_last), 32'(beats == n - 1));
          beats++;
        end
      end
      @(negedge clk);
      wr_en = 1'b0;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (done_cyc < 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("done_latency", 32'(done_cyc), 32'(2 * n + stall_len));
      check("busy_in_done", 32'(busy), 32'd1);
      check("beat_count", 32'(beats), 32'(n));
      check("checksum", checksum, exp_csum);
      @(negedge clk);
      check("done_pulse_end", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("checksum_hold", checksum, exp_csum);
    end
  endtask

  initial begin
    exp_mem[0] = 32'h11111111;
    exp_mem[1] = 32'h22222222;
    exp_mem[2] = 32'h33333333;
    exp_mem[3] = 32'h44444444;
    load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load = 1'b0;
    check("rst_raddr", 32'(rf_read_addr), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_csum", checksum, 32'd0);
    rst_n = 1'b1;

    // Full dump, wrap, backpressure, count 0 and clamp
    do_start(2'd0, 3'd4); collect(2'd0, 4, -1, 0, -1, 32'h44444444);
    do_start(2'd3, 3'd2); collect(2'd3, 2, -1, 0, -1, 32'h55555555);
    do_start(2'd0, 3'd4); collect(2'd0, 4, 1, 5, -1, 32'h44444444);
    do_start(2'd0, 3'd0); collect(2'd0, 0, -1, 0, -1, 32'h00000000);
    do_start(2'd0, 3'd7); collect(2'd0, 4, -1, 0, -1, 32'h44444444);

    // start while busy is ignored
    do_start(2'd3, 3'd2); collect(2'd3, 2, -1, 0, 2, 32'h55555555);

    // Reset during SEND
    do_start(2'd0, 3'd4);
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_csum", checksum, 32'd0);
    @(negedge clk);
    check("mid_rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", 32'(done), 32'd0);
    do_start(2'd0, 3'd4); collect(2'd0, 4, -1, 0, -1, 32'h44444444);

    // Write to R1 in its READ cycle is not seen; the next dump sees it
    do_start(2'd1, 3'd1);
    wr_en = 1'b1;
    wr_addr = 2'd1;
    wr_data = 32'hDEADBEEF;
    collect(2'd1, 1, -1, 0, -1, 32'h22222222);
    exp_mem[1] = 32'hDEADBEEF;
    do_start(2'd1, 3'd1); collect(2'd1, 1, -1, 0, -1, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
